ext_in_cntrl: RTL and testbench

Input-port controller for the SimpleCPU IN instruction (opcode 4'h7). It is the receiving counterpart of the external output path. It accepts bytes from an external producer over a valid/ready handshake and buffers them in a small FIFO. It presents the oldest byte to the EXE-stage write-back mux and raises a stall when an IN instruction executes against an empty buffer, so the PC and pipeline hold until data arrives.

---
 rtl/ext_in_cntrl.sv | 103 ++++++++++
 tb/tb_ext_in_cntrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ext_in_cntrl.sv
// ---------------------------------------------------------------------------
// ext_in_cntrl
//
// Input-port controller for the SimpleCPU IN instruction (opcode 4'h7).
// Bytes from an external producer arrive over a valid/ready handshake and
// are buffered in a small first-word-fall-through FIFO. The oldest byte is
// presented to the EXE-stage write-back mux. An IN that executes against an
// empty buffer raises in_stall so the PC and pipeline hold until data lands.
//
// Ports:
//   clk        in   clock, all state updates on posedge
//   rst        in   asynchronous active-high reset
//   ext_data   in   [7:0] byte offered by the external producer
//   ext_valid  in   producer has a byte on ext_data
//   ext_ready  out  controller accepts a byte this cycle
//   op         in   [3:0] opcode of the instruction currently in EXE
//   in_data    out  [7:0] oldest buffered byte (8'h00 when empty)
//   in_stall   out  IN against an empty buffer; hold PC and insert a bubble
//   count      out  [AW:0] number of buffered bytes, 0..DEPTH
// ---------------------------------------------------------------------------
module ext_in_cntrl #(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    ext_data,
    input  logic          ext_valid,
    output logic          ext_ready,
    input  logic [3:0]    op,
    output logic [7:0]    in_data,
    output logic          in_stall,
    output logic [AW:0]   count
);

    localparam logic [3:0]  OP_IN    = 4'h7;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic empty;
    logic full;
    logic push;
    logic rd_req;
    logic pop;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == FULL_CNT);

    // Ready comes only from registered occupancy and rst, so there is no
    // combinational path from ext_valid or op. A pop while full therefore
    // frees a slot only from the next cycle on.
    assign ext_ready = !rst && !full;
    assign push      = ext_valid && ext_ready;

    assign rd_req = (op == OP_IN);
    assign pop    = rd_req && !empty;

    // No empty bypass: a byte pushed this cycle is only visible next cycle.
    assign in_data  = empty ? 8'h00 : mem_q[rp_q];
    assign in_stall = rd_req && empty;
    assign count    = cnt_q;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (push) begin
            wp_d = wp_q + AW'(1);   // power-of-two depth: wraps naturally
        end
        if (pop) begin
            rp_d = rp_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage contents are don't-care after reset; occupancy gates the output.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= ext_data;
        end
    end

endmodule

// File: tb/tb_ext_in_cntrl.sv
module tb_ext_in_cntrl;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    ext_data;
    logic          ext_valid;
    logic          ext_ready;
    logic [3:0]    op;
    logic [7:0]    in_data;
    logic          in_stall;
    logic [AW:0]   count;

    int n_tests = 0;
    int n_fail  = 0;

    ext_in_cntrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ext_data  (ext_data),
        .ext_valid (ext_valid),
        .ext_ready (ext_ready),
        .op        (op),
        .in_data   (in_data),
        .in_stall  (in_stall),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic [3:0] op;
        logic       exp_ready;
        logic [7:0] exp_data;
        logic       exp_stall;
        logic [AW:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic v,
                       input logic [7:0] d, input logic [3:0] o,
                       input logic er, input logic [7:0] ed,
                       input logic es, input logic [AW:0] ec);
        vec_t t;
        t.name = name; t.rst = r; t.valid = v; t.data = d; t.op = o;
        t.exp_ready = er; t.exp_data = ed; t.exp_stall = es; t.exp_count = ec;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic er, input logic [7:0] ed,
                           input logic es, input logic [AW:0] ec);
        chk({name, ".ready"}, 32'(ext_ready), 32'(er));
        chk({name, ".data"},  32'(in_data),   32'(ed));
        chk({name, ".stall"}, 32'(in_stall),  32'(es));
        chk({name, ".count"}, 32'(count),     32'(ec));
        $display("[TB] %-14s rst=%0b v=%0b d=%02h op=%h | rdy=%0b data=%02h stall=%0b cnt=%0d",
                 name, rst, ext_valid, ext_data, op, ext_ready, in_data, in_stall, count);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ext_valid = 1'b0; ext_data = 8'h00; op = 4'h7;

        //   name            rst v  data   op    rdy  data   stl cnt
        add("rst_idle",      1, 0, 8'h00, 4'h7, 0, 8'h00, 1, 0);
        add("rst_pending",   1, 1, 8'hEE, 4'h7, 0, 8'h00, 1, 0);
        add("post_rst",      0, 0, 8'h00, 4'h0, 1, 8'h00, 0, 0);
        add("push_a5",       0, 1, 8'hA5, 4'h0, 1, 8'h00, 0, 0);
        add("in_a5",         0, 0, 8'h00, 4'h7, 1, 8'hA5, 0, 1);
        add("after_in",      0, 0, 8'h00, 4'h0, 1, 8'h00, 0, 0);
        add("stall1",        0, 0, 8'h00, 4'h7, 1, 8'h00, 1, 0);
        add("stall2",        0, 0, 8'h00, 4'h7, 1, 8'h00, 1, 0);
        add("stall3_push",   0, 1, 8'h3C, 4'h7, 1, 8'h00, 1, 0);
        add("stall_recov",   0, 0, 8'h00, 4'h7, 1, 8'h3C, 0, 1);
        add("drained",       0, 0, 8'h00, 4'h0, 1, 8'h00, 0, 0);
        add("fill_01",       0, 1, 8'h01, 4'h0, 1, 8'h00, 0, 0);
        add("fill_02",       0, 1, 8'h02, 4'h0, 1, 8'h01, 0, 1);
        add("fill_03",       0, 1, 8'h03, 4'h0, 1, 8'h01, 0, 2);
        add("fill_04",       0, 1, 8'h04, 4'h0, 1, 8'h01, 0, 3);
        add("full_05",       0, 1, 8'h05, 4'h0, 0, 8'h01, 0, 4);
        add("full_hold",     0, 1, 8'h05, 4'h0, 0, 8'h01, 0, 4);
        add("full_pop",      0, 1, 8'h05, 4'h7, 0, 8'h01, 0, 4);
        add("ready_again",   0, 1, 8'h05, 4'h0, 1, 8'h02, 0, 3);
        add("drain_02",      0, 0, 8'h00, 4'h7, 0, 8'h02, 0, 4);
        add("drain_03",      0, 0, 8'h00, 4'h7, 1, 8'h03, 0, 3);
        add("drain_04",      0, 0, 8'h00, 4'h7, 1, 8'h04, 0, 2);
        add("drain_05",      0, 0, 8'h00, 4'h7, 1, 8'h05, 0, 1);
        add("drain_empty",   0, 0, 8'h00, 4'h7, 1, 8'h00, 1, 0);
        add("other_op_emp",  0, 0, 8'h00, 4'hF, 1, 8'h00, 0, 0);
        add("push_77",       0, 1, 8'h77, 4'h3, 1, 8'h00, 0, 0);
        add("other_op_1",    0, 0, 8'h00, 4'h3, 1, 8'h77, 0, 1);
        add("other_op_2",    0, 0, 8'h00, 4'h6, 1, 8'h77, 0, 1);
        add("in_77",         0, 0, 8'h00, 4'h7, 1, 8'h77, 0, 1);
        add("empty_end",     0, 0, 8'h00, 4'h0, 1, 8'h00, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; ext_valid = vecs[i].valid;
            ext_data = vecs[i].data; op = vecs[i].op;
            #2;
            chk_all(vecs[i].name, vecs[i].exp_ready, vecs[i].exp_data,
                    vecs[i].exp_stall, vecs[i].exp_count);
            next_cycle();
        end

        // Streaming push+pop with wrap: 16 bytes, IN every cycle after the first push.
        for (int k = 0; k <= 16; k++) begin
            ext_valid = (k < 16);
            ext_data  = 8'h10 + 8'(k);
            op        = (k >= 1) ? 4'h7 : 4'h0;
            #2;
            if (k == 0)
                chk_all($sformatf("stream_%0d", k), 1'b1, 8'h00, 1'b0, 0);
            else
                chk_all($sformatf("stream_%0d", k), 1'b1, 8'h10 + 8'(k - 1), 1'b0, 1);
            next_cycle();
        end
        ext_valid = 1'b0; op = 4'h0;
        #2;
        chk_all("stream_end", 1'b1, 8'h00, 1'b0, 0);
        next_cycle();

        // Reset mid-operation: load three bytes, then pulse rst between edges.
        for (int k = 0; k < 3; k++) begin
            ext_valid = 1'b1; ext_data = 8'hA1 + 8'(k); op = 4'h0;
            next_cycle();
        end
        ext_valid = 1'b0;
        #2;
        chk_all("pre_rst3", 1'b1, 8'hA1, 1'b0, 3);
        rst = 1'b1;
        #1;
        chk_all("mid_rst", 1'b0, 8'h00, 1'b0, 0);
        rst = 1'b0;
        #1;
        chk_all("mid_rst_rel", 1'b1, 8'h00, 1'b0, 0);
        next_cycle();
        op = 4'h7;
        #2;
        chk_all("post_rst_in", 1'b1, 8'h00, 1'b1, 0);
        next_cycle();
        ext_valid = 1'b1; ext_data = 8'hB1;
        #2;
        chk_all("post_rst_push", 1'b1, 8'h00, 1'b1, 0);
        next_cycle();
        ext_valid = 1'b0;
        #2;
        chk_all("post_rst_done", 1'b1, 8'hB1, 1'b0, 1);
        next_cycle();
        op = 4'h0;
        #2;
        chk_all("final", 1'b1, 8'h00, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
